// File: rtl/amb_geri_yazma_tamponu.sv
// Write-back buffer between the AMB result and the single register-file write port.
// Memory-unit writes own the port; ALU results wait in an in-order FIFO and can be forwarded.
module amb_geri_yazma_tamponu #(
    parameter int DERINLIK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        amb_hazir_i,
    input  logic [31:0] amb_sonuc_i,
    input  logic        amb_yaz_i,
    input  logic [4:0]  amb_hedef_yazmac_i,
    input  logic        bellek_gecerli_i,
    input  logic [31:0] bellek_veri_i,
    input  logic [4:0]  bellek_hedef_yazmac_i,
    output logic        durdur_o,
    output logic        yaz_gecerli_o,
    output logic [4:0]  yaz_adres_o,
    output logic [31:0] yaz_veri_o,
    input  logic [4:0]  ileri_sorgu_adres_i,
    output logic        ileri_gecerli_o,
    output logic [31:0] ileri_veri_o
);

    localparam int PTR_W = $clog2(DERINLIK);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]         veri_q   [DERINLIK];
    logic [4:0]          adres_q  [DERINLIK];
    logic [DERINLIK-1:0] gecerli_q;
    logic [PTR_W-1:0]    oku_ptr;
    logic [PTR_W-1:0]    yaz_ptr;
    logic [CNT_W-1:0]    sayac;
    logic                it;
    logic                cek;
    logic [PTR_W-1:0]    idx;

    // Handshake: a result is taken when amb_hazir_i is high and durdur_o is low; while
    // durdur_o is high the AMB re-presents the same result, which is taken once the stall drops.
    assign durdur_o = (sayac == CNT_W'(DERINLIK));
    assign it  = amb_hazir_i & amb_yaz_i & (amb_hedef_yazmac_i != 5'd0) & ~durdur_o;
    assign cek = ~bellek_gecerli_i & (sayac != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oku_ptr       <= '0;
            yaz_ptr       <= '0;
            sayac         <= '0;
            gecerli_q     <= '0;
            yaz_gecerli_o <= 1'b0;
            yaz_adres_o   <= 5'd0;
            yaz_veri_o    <= 32'd0;
        end else begin
            if (bellek_gecerli_i) begin
                // The memory write is younger than everything buffered, so older writes to its rd die.
                for (int i = 0; i < DERINLIK; i++) begin
                    if (adres_q[i] == bellek_hedef_yazmac_i) gecerli_q[i] <= 1'b0;
                end
                yaz_gecerli_o <= 1'b1;
                yaz_adres_o   <= bellek_hedef_yazmac_i;
                yaz_veri_o    <= bellek_veri_i;
            end else if (cek) begin
                yaz_gecerli_o <= gecerli_q[oku_ptr];
                yaz_adres_o   <= adres_q[oku_ptr];
                yaz_veri_o    <= veri_q[oku_ptr];
                oku_ptr       <= oku_ptr + 1'b1;
            end else begin
                yaz_gecerli_o <= 1'b0;
            end

            if (it) begin
                veri_q[yaz_ptr]    <= amb_sonuc_i;
                adres_q[yaz_ptr]   <= amb_hedef_yazmac_i;
                gecerli_q[yaz_ptr] <= 1'b1;
                yaz_ptr            <= yaz_ptr + 1'b1;
            end

            case ({it, cek})
                2'b10:   sayac <= sayac + 1'b1;
                2'b01:   sayac <= sayac - 1'b1;
                default: sayac <= sayac;
            endcase
        end
    end

    // Walk oldest to youngest so the last hit (the youngest) wins; the write register is oldest.
    always_comb begin
        ileri_gecerli_o = 1'b0;
        ileri_veri_o    = 32'd0;
        idx             = oku_ptr;
        if (ileri_sorgu_adres_i != 5'd0) begin
            if (yaz_gecerli_o && (yaz_adres_o == ileri_sorgu_adres_i)) begin
                ileri_gecerli_o = 1'b1;
                ileri_veri_o    = yaz_veri_o;
            end
            for (int k = 0; k < DERINLIK; k++) begin
                idx = oku_ptr + PTR_W'(k);
                if ((CNT_W'(k) < sayac) && gecerli_q[idx] &&
                    (adres_q[idx] == ileri_sorgu_adres_i)) begin
                    ileri_gecerli_o = 1'b1;
                    ileri_veri_o    = veri_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_amb_geri_yazma_tamponu.sv
// Bench for amb_geri_yazma_tamponu: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the buffer.
module tb_amb_geri_yazma_tamponu;

    localparam int DERINLIK = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        amb_hazir_i;
    logic [31:0] amb_sonuc_i;
    logic        amb_yaz_i;
    logic [4:0]  amb_hedef_yazmac_i;
    logic        bellek_gecerli_i;
    logic [31:0] bellek_veri_i;
    logic [4:0]  bellek_hedef_yazmac_i;
    logic        durdur_o;
    logic        yaz_gecerli_o;
    logic [4:0]  yaz_adres_o;
    logic [31:0] yaz_veri_o;
    logic [4:0]  ileri_sorgu_adres_i;
    logic        ileri_gecerli_o;
    logic [31:0] ileri_veri_o;

    amb_geri_yazma_tamponu #(.DERINLIK(DERINLIK)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .amb_hazir_i           (amb_hazir_i),
        .amb_sonuc_i           (amb_sonuc_i),
        .amb_yaz_i             (amb_yaz_i),
        .amb_hedef_yazmac_i    (amb_hedef_yazmac_i),
        .bellek_gecerli_i      (bellek_gecerli_i),
        .bellek_veri_i         (bellek_veri_i),
        .bellek_hedef_yazmac_i (bellek_hedef_yazmac_i),
        .durdur_o              (durdur_o),
        .yaz_gecerli_o         (yaz_gecerli_o),
        .yaz_adres_o           (yaz_adres_o),
        .yaz_veri_o            (yaz_veri_o),
        .ileri_sorgu_adres_i   (ileri_sorgu_adres_i),
        .ileri_gecerli_o       (ileri_gecerli_o),
        .ileri_veri_o          (ileri_veri_o)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Scoreboard: buffered entries {valid, rd, data}, oldest at the front.
    logic [37:0] exp_q[$];
    logic        exp_yg;
    logic [4:0]  exp_ya;
    logic [31:0] exp_yd;
    int          n_kontrol = 0;
    int          n_hata    = 0;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_kontrol++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: gozlenen=%h beklenen=%h t=%0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registers.
    task automatic adim(input logic rst, input logic hazir, input logic yaz, input logic [4:0] rd,
                        input logic [31:0] sonuc, input logic bel, input logic [4:0] brd,
                        input logic [31:0] bveri, input logic [4:0] sorgu);
        logic        f_g;
        logic [31:0] f_v;
        logic        dolu;
        logic [37:0] e;
        rst_i = rst; amb_hazir_i = hazir; amb_yaz_i = yaz; amb_hedef_yazmac_i = rd;
        amb_sonuc_i = sonuc; bellek_gecerli_i = bel; bellek_hedef_yazmac_i = brd;
        bellek_veri_i = bveri; ileri_sorgu_adres_i = sorgu;
        #2;
        f_g = 1'b0; f_v = 32'd0;
        if (sorgu != 5'd0) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                e = exp_q[i];
                if (!f_g && e[37] && e[36:32] == sorgu) begin f_g = 1'b1; f_v = e[31:0]; end
            end
            if (!f_g && exp_yg && exp_ya == sorgu) begin f_g = 1'b1; f_v = exp_yd; end
        end
        kontrol("ileri_gecerli", ileri_gecerli_o, f_g);
        kontrol("ileri_veri", ileri_veri_o, f_v);
        dolu = (exp_q.size() == DERINLIK);
        kontrol("durdur", durdur_o, dolu);
        if (rst) begin
            exp_q.delete();
            exp_yg = 1'b0; exp_ya = 5'd0; exp_yd = 32'd0;
        end else begin
            if (bel) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    e = exp_q[i];
                    if (e[36:32] == brd) begin e[37] = 1'b0; exp_q[i] = e; end
                end
                exp_yg = 1'b1; exp_ya = brd; exp_yd = bveri;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_yg = e[37]; exp_ya = e[36:32]; exp_yd = e[31:0];
            end else begin
                exp_yg = 1'b0;
            end
            if (hazir && yaz && rd != 5'd0 && !dolu) exp_q.push_back({1'b1, rd, sonuc});
        end
        @(posedge clk);
        #1;
        kontrol("yaz_gecerli", yaz_gecerli_o, exp_yg);
        kontrol("yaz_adres", yaz_adres_o, exp_ya);
        kontrol("yaz_veri", yaz_veri_o, exp_yd);
    endtask

    task automatic bos(input int n);
        for (int i = 0; i < n; i++) adim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic        h_hazir, h_yaz, h_bel;
    logic [4:0]  h_rd;
    logic [31:0] h_son;

    initial begin
        exp_yg = 1'b0; exp_ya = 5'd0; exp_yd = 32'd0;
        adim(1, 0, 0, 0, 0, 0, 0, 0, 0);
        adim(1, 0, 0, 0, 0, 0, 0, 0, 0);
        kontrol("reset_durdur", durdur_o, 0);
        kontrol("reset_yaz_veri", yaz_veri_o, 0);

        // Single push, visible after the following edge.
        adim(0, 1, 1, 5'd5, 32'h0000_00AA, 0, 0, 0, 0);
        adim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        kontrol("tek_gecerli", yaz_gecerli_o, 1);
        kontrol("tek_adres", yaz_adres_o, 5);
        kontrol("tek_veri", yaz_veri_o, 32'hAA);
        adim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        kontrol("tek_sonra", yaz_gecerli_o, 0);

        // Fill under constant memory traffic; fifth result is held until the stall drops.
        for (int j = 0; j < 4; j++)
            adim(0, 1, 1, 5'(j + 1), 32'(j + 'h100), 1, 5'd20, 32'(j), 0);
        kontrol("dolu_durdur", durdur_o, 1);
        adim(0, 1, 1, 5'd6, 32'h600, 1, 5'd20, 32'h55, 0);
        kontrol("dolu_tutuldu", durdur_o, 1);
        adim(0, 1, 1, 5'd6, 32'h600, 0, 0, 0, 0);
        kontrol("ilk_cekis_adres", yaz_adres_o, 1);
        adim(0, 1, 1, 5'd6, 32'h600, 0, 0, 0, 0);
        bos(6);
        kontrol("bosaldi", durdur_o, 0);

        // Squash: buffered rd=7 overwritten by a younger memory write.
        adim(0, 1, 1, 5'd7, 32'h11, 1, 5'd9, 32'h99, 0);
        adim(0, 0, 0, 0, 0, 1, 5'd7, 32'h22, 7);
        kontrol("ezme_adres", yaz_adres_o, 7);
        kontrol("ezme_veri", yaz_veri_o, 32'h22);
        adim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        kontrol("ezme_cekis", yaz_gecerli_o, 0);
        bos(2);

        // Forwarding: youngest of two rd=3 entries wins.
        adim(0, 1, 1, 5'd3, 32'h1, 1, 5'd9, 32'h9, 0);
        adim(0, 1, 1, 5'd3, 32'h2, 1, 5'd9, 32'h9, 3);
        ileri_sorgu_adres_i = 5'd3; #1;
        kontrol("ileri_genc_g", ileri_gecerli_o, 1);
        kontrol("ileri_genc_v", ileri_veri_o, 32'h2);
        ileri_sorgu_adres_i = 5'd4; #1;
        kontrol("ileri_kacir", {31'd0, ileri_gecerli_o} | ileri_veri_o, 0);
        ileri_sorgu_adres_i = 5'd0; #1;
        kontrol("ileri_x0", {31'd0, ileri_gecerli_o} | ileri_veri_o, 0);
        bos(4);

        // Dropped results create no entries.
        adim(0, 1, 0, 5'd5, 32'h77, 0, 0, 0, 0);
        adim(0, 1, 1, 5'd0, 32'h78, 0, 0, 0, 0);
        adim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        kontrol("dusur_yaz", yaz_gecerli_o, 0);

        // Reset with three buffered entries.
        for (int j = 0; j < 3; j++)
            adim(0, 1, 1, 5'(j + 10), 32'(j + 'h300), 1, 5'd21, 32'h5, 0);
        adim(1, 0, 0, 0, 0, 0, 0, 0, 0);
        kontrol("orta_reset_durdur", durdur_o, 0);
        kontrol("orta_reset_yaz", yaz_gecerli_o, 0);
        bos(4);

        // Random traffic with an AMB that holds its result while stalled.
        h_hazir = 0; h_yaz = 0; h_rd = 0; h_son = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!(exp_q.size() == DERINLIK && h_hazir && h_yaz && h_rd != 0)) begin
                h_hazir = ($urandom_range(0, 3) != 0);
                h_yaz   = ($urandom_range(0, 7) != 0);
                h_rd    = 5'($urandom_range(0, 7));
                h_son   = $urandom;
            end
            h_bel = ($urandom_range(0, 1) == 1);
            adim(($urandom_range(0, 99) == 0), h_hazir, h_yaz, h_rd, h_son, h_bel,
                 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_kontrol, n_hata);
        $finish;
    end

endmodule
